raw2rgb_frame_seq: RTL and testbench
====================================

// Module: raw2rgb_frame_seq
// PURPOSE
//  Frame/line sequencer in front of the Bayer demosaic stage.
//  - Arms on a clean frame boundary from sensor frame/line valids.
//  - Registers raw pixels; generates per-pixel column/row counts for the demosaic's parity decode.
//  - Holds the demosaic output gate low while its 2-line buffer primes.
//  - Reports frame start/done, frame count and line-length errors.
// PARAMETERS
//  H_ACTIVE     1280  pixels per line accepted; extra pixels suppressed and flagged
//  V_ACTIVE     1024  lines per frame accepted; extra lines suppressed and flagged
//  PRIME_LINES  2     lines at frame start during which oOutEn stays low
//  CNT_W        16    width of oX_Cont / oY_Cont
// PORTS
//  iCLK          in   1      pixel clock; all logic on rising edge
//  iRST_n        in   1      reset, asynchronous, active-low
//  iStart        in   1      level: enable capture (armed at next frame boundary)
//  iStop         in   1      level: finish current frame, then go idle
//  iFval         in   1      sensor frame valid
//  iLval         in   1      sensor line valid
//  iData         in   12     raw Bayer pixel
//  oData         out  12     registered pixel to demosaic
//  oDval         out  1      pixel valid to demosaic
//  oX_Cont       out  CNT_W  column of pixel on oData
//  oY_Cont       out  CNT_W  row of pixel on oData
//  oOutEn        out  1      demosaic output gate
//  oFrameStart   out  1      1-cycle pulse, first accepted pixel of a frame
//  oFrameDone    out  1      1-cycle pulse, frame closed
//  oFrame_Cont   out  32     completed-frame count, wraps 2^32-1 -> 0
//  oLineErr      out  1      sticky: a line had length != H_ACTIVE, or a frame exceeded V_ACTIVE lines
//  oBusy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: every output 0; state IDLE; all counters 0.
//  Reset mid-frame: after release, restart in IDLE.
//  Input stage: iFval/iLval/iData registered once (_d). Outputs derive from _d -> 1-cycle latency, in->oData.
//  FSM:
//   IDLE   -> ARMED on iStart=1 and iStop=0. iStop wins if both are high.
//   ARMED  -> WAIT_FV when iFval_d=0 is seen. A frame already in progress is never captured.
//   WAIT_FV-> ACTIVE on iFval_d rising edge. Clear X, Y and the line-pixel count.
//             iStop in ARMED/WAIT_FV -> IDLE.
//   ACTIVE -> DONE on iFval_d falling edge.
//   DONE   -> 1 cycle: oFrameDone=1, oFrame_Cont++.
//             Next state: IDLE if iStop=1 or iStart=0; else WAIT_FV.
//  iStop during ACTIVE: the current frame completes normally. It is latched and applied in DONE.
//  oDval = iFval_d & iLval_d & (X < H_ACTIVE) & (Y < V_ACTIVE), only in ACTIVE. 0 in all other states.
//  oData updates every cycle with iData_d, whether or not oDval is high.
//  X: 0 on each line start. +1 after each oDval pixel. Saturates at H_ACTIVE. Never wraps.
//  Y: +1 on iLval_d falling edge in ACTIVE, only if the line had >=1 pixel. Saturates at V_ACTIVE.
//  oX_Cont/oY_Cont always show the X/Y of the current oData pixel.
//  Line end: if the raw pixel count != H_ACTIVE, set oLineErr.
//   Pixel count includes suppressed pixels; it saturates at 2*H_ACTIVE.
//  Line start with Y==V_ACTIVE: set oLineErr. That line produces no oDval.
//  oLineErr clears only on reset or on the IDLE->ARMED transition.
//  oOutEn = ACTIVE & (Y >= PRIME_LINES). Drops with oDval rules at frame end.
//  oFrameStart: first oDval of a frame (X=0, Y=0).
//  Frame ends with iLval_d still high: treat as line end (Y/err update), then DONE.
//  iLval_d high while iFval_d low: ignored.
// TESTING (H_ACTIVE=8, V_ACTIVE=4, PRIME_LINES=2)
//  1. iStart=1, clean 4x8 frame, iData=ramp.
//     -> 32 oDval, X 0..7, Y 0..3, oData=ramp delayed 1 cycle.
//     -> oOutEn high only for Y=2,3. 1 oFrameStart, 1 oFrameDone, oFrame_Cont=1, oLineErr=0.
//  2. iStart asserted mid-frame (iFval high).
//     -> no oDval until the next full frame; that frame is captured from Y=0.
//  3. Line of 10 pixels -> only 8 oDval, X stays 7 then 8 with no oDval, oLineErr=1.
//     Line of 6 pixels -> 6 oDval, oLineErr=1, Y still advances.
//  4. 5-line frame -> 5th line has no oDval, oLineErr=1, one oFrameDone.
//  5. iStop pulsed at Y=1 -> frame completes with 32 oDval, oFrameDone, state IDLE.
//     Next frame ignored. iStart & iStop together in IDLE -> stays IDLE.
//  6. iRST_n low at Y=2 -> all outputs 0 asynchronously.
//     With iStart held, capture resumes only at the next full frame; oFrame_Cont restarts at 0.

Source files
------------

// File: rtl/raw2rgb_frame_seq.sv
// Frame/line sequencer ahead of the Bayer demosaic: arms on a clean frame boundary, registers
// raw pixels, tracks column/row for parity decode, gates demosaic output and flags bad geometry.
module raw2rgb_frame_seq #(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 1024,
    parameter int unsigned PRIME_LINES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iFval,
    input  logic             iLval,
    input  logic [11:0]      iData,
    output logic [11:0]      oData,
    output logic             oDval,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oOutEn,
    output logic             oFrameStart,
    output logic             oFrameDone,
    output logic [31:0]      oFrame_Cont,
    output logic             oLineErr,
    output logic             oBusy
);

    localparam int unsigned PIX_W = $clog2(2 * H_ACTIVE + 1);

    localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] PRIME   = CNT_W'(PRIME_LINES);
    localparam logic [PIX_W-1:0] PIX_H   = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(2 * H_ACTIVE);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_WAIT_FV = 3'd2;
    localparam logic [2:0] ST_ACTIVE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             fval_q, lval_q, fval_prev_q, line_prev_q;
    logic [11:0]      data_q;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             err_q, err_d;
    logic             stop_q, stop_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;

    logic line_act, line_start, line_end, fv_rise, fv_fall, in_active, dval;

    always_comb begin
        // Line valid outside frame valid is ignored entirely.
        line_act   = fval_q & lval_q;
        line_start = line_act & ~line_prev_q;
        line_end   = ~line_act & line_prev_q;
        fv_rise    = fval_q & ~fval_prev_q;
        fv_fall    = ~fval_q & fval_prev_q;
        in_active  = (state_q == ST_ACTIVE);
        dval       = in_active & line_act & (x_q < H_LIM) & (y_q < V_LIM);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        err_d       = err_q;
        stop_d      = stop_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart && !iStop) begin
                    state_d = ST_ARMED;
                    err_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (iStop) state_d = ST_IDLE;
                else if (!fval_q) state_d = ST_WAIT_FV;
            end
            ST_WAIT_FV: begin
                if (iStop) begin
                    state_d = ST_IDLE;
                end else if (fv_rise) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    pix_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (iStop) stop_d = 1'b1;
                if (line_act) begin
                    if (line_start) pix_d = PIX_W'(1);
                    else if (pix_q < PIX_MAX) pix_d = pix_q + 1'b1;
                    if (line_start && (y_q == V_LIM)) err_d = 1'b1;
                    if (dval) x_d = x_q + 1'b1;
                end else begin
                    // X parks at 0 between lines so a new line starts at column 0.
                    x_d = '0;
                    if (line_end) begin
                        if (pix_q != PIX_H) err_d = 1'b1;
                        if ((pix_q != '0) && (y_q < V_LIM)) y_d = y_q + 1'b1;
                        pix_d = '0;
                    end
                end
                if (fv_fall) begin
                    state_d     = ST_DONE;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = (stop_q || iStop || !iStart) ? ST_IDLE : ST_WAIT_FV;
                stop_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            fval_prev_q <= 1'b0;
            line_prev_q <= 1'b0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_q       <= '0;
            err_q       <= 1'b0;
            stop_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fval_q      <= iFval;
            lval_q      <= iLval;
            fval_prev_q <= fval_q;
            line_prev_q <= line_act;
            data_q      <= iData;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oData       = data_q;
    assign oDval       = dval;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oOutEn      = in_active & (y_q >= PRIME);
    assign oFrameStart = dval & (x_q == '0) & (y_q == '0);
    assign oFrameDone  = (state_q == ST_DONE);
    assign oFrame_Cont = frame_cnt_q;
    assign oLineErr    = err_q;
    assign oBusy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_raw2rgb_frame_seq.sv
// Scoreboarded bench for raw2rgb_frame_seq: a frame driver pushes expected pixels derived from
// the frame geometry; a negedge monitor pops and compares every accepted pixel.
module tb_raw2rgb_frame_seq;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int PRIME = 2;

    logic        iCLK, iRST_n, iStart, iStop, iFval, iLval;
    logic [11:0] iData, oData;
    logic        oDval, oOutEn, oFrameStart, oFrameDone, oLineErr, oBusy;
    logic [15:0] oX_Cont, oY_Cont;
    logic [31:0] oFrame_Cont;

    raw2rgb_frame_seq #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .PRIME_LINES(PRIME),
        .CNT_W      (16)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iStart     (iStart),
        .iStop      (iStop),
        .iFval      (iFval),
        .iLval      (iLval),
        .iData      (iData),
        .oData      (oData),
        .oDval      (oDval),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oOutEn     (oOutEn),
        .oFrameStart(oFrameStart),
        .oFrameDone (oFrameDone),
        .oFrame_Cont(oFrame_Cont),
        .oLineErr   (oLineErr),
        .oBusy      (oBusy)
    );

    typedef struct packed {
        logic [11:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic        oe;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   exp_frames = 0;
    bit   exp_after_done = 1'b1;
    bit   chk_busy_next = 1'b0;
    int   line_len[8];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    // Monitor: one pop per accepted pixel, plus frame-done bookkeeping.
    always @(negedge iCLK) begin
        if (!iRST_n) begin
            done_seen     = 0;
            chk_busy_next = 1'b0;
        end else begin
            if (chk_busy_next) begin
                chk("busy_after_done", 64'(oBusy), 64'(exp_after_done));
                chk_busy_next = 1'b0;
            end
            if (oFrameDone) begin
                done_seen++;
                chk_busy_next = 1'b1;
            end
            if (oDval) begin
                chk("dval_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("pixel", 64'({oData, oX_Cont, oY_Cont, oOutEn, oFrameStart}),
                        64'(mon_e));
                end
            end else begin
                chk("fstart_without_dval", 64'(oFrameStart), 64'(0));
            end
        end
    end

    task automatic do_reset();
        iRST_n = 1'b0;
        #1;
        chk("async_reset_outs", 64'({oData, oDval, oX_Cont, oY_Cont, oOutEn, oFrameStart,
                                     oFrameDone, oLineErr, oBusy}), 64'(0));
        chk("async_reset_frame_cont", 64'(oFrame_Cont), 64'(0));
        exp_q.delete();
        exp_frames = 0;
        cyc();
        cyc();
        iRST_n = 1'b1;
    endtask

    task automatic set_lens(input int n, input int len);
        for (int l = 0; l < n; l++) line_len[l] = len;
    endtask

    task automatic send_frame(input int nl, input bit cap_in, input int start_line,
                              input int stop_line, input int rst_line);
        bit   cap;
        exp_t e;
        cap   = cap_in;
        iFval = 1'b1;
        cyc();
        cyc();
        for (int l = 0; l < nl; l++) begin
            if (l == start_line) iStart = 1'b1;
            if (l == stop_line) iStop = 1'b1;
            for (int p = 0; p < line_len[l]; p++) begin
                if (l == rst_line && p == 3) begin
                    do_reset();
                    cap = 1'b0;
                end
                iData = 12'($urandom);
                iLval = 1'b1;
                if (cap && l < V && p < H) begin
                    e.d  = iData;
                    e.x  = 16'(p);
                    e.y  = 16'(l);
                    e.oe = (l >= PRIME);
                    e.fs = (l == 0 && p == 0);
                    exp_q.push_back(e);
                end
                cyc();
                if (cap && l < V && p >= H)
                    chk("x_saturate", 64'({oDval, oX_Cont}), 64'({1'b0, 16'(H)}));
            end
            iLval = 1'b0;
            if (l == stop_line) iStop = 1'b0;
            repeat (3) cyc();
        end
        iFval = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic check_frame(input bit exp_err);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("frame_cont", 64'(oFrame_Cont), 64'(exp_frames));
        chk("frame_done_pulses", 64'(done_seen), 64'(exp_frames));
        chk("line_err", 64'(oLineErr), 64'(exp_err));
    endtask

    task automatic go_idle();
        iStop  = 1'b1;
        iStart = 1'b0;
        repeat (3) cyc();
        iStop = 1'b0;
        cyc();
        chk("idle_after_stop", 64'(oBusy), 64'(0));
    endtask

    task automatic arm();
        iStart = 1'b1;
        cyc();
        cyc();
        chk("armed_busy", 64'(oBusy), 64'(1));
        chk("err_cleared_on_arm", 64'(oLineErr), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int  nl;
        bit  err;
        iRST_n = 1'b0;
        iStart = 1'b0;
        iStop  = 1'b0;
        iFval  = 1'b0;
        iLval  = 1'b0;
        iData  = '0;
        repeat (3) cyc();
        chk("reset_outs", 64'({oData, oDval, oX_Cont, oY_Cont, oOutEn, oFrameStart,
                               oFrameDone, oLineErr, oBusy}), 64'(0));
        chk("reset_frame_cont", 64'(oFrame_Cont), 64'(0));
        iRST_n = 1'b1;
        cyc();
        cyc();
        chk("idle_after_reset", 64'(oBusy), 64'(0));

        // Clean 4x8 frame.
        arm();
        set_lens(4, H);
        send_frame(4, 1'b1, -1, -1, -1);
        exp_frames++;
        check_frame(1'b0);

        // Start raised mid-frame: that frame is skipped, the next is captured.
        go_idle();
        send_frame(4, 1'b0, 1, -1, -1);
        chk("mid_frame_start_cont", 64'(oFrame_Cont), 64'(exp_frames));
        chk("mid_frame_start_busy", 64'(oBusy), 64'(1));
        send_frame(4, 1'b1, -1, -1, -1);
        exp_frames++;
        check_frame(1'b0);

        // Long and short lines.
        line_len[0] = H;
        line_len[1] = H + 2;
        line_len[2] = H - 2;
        line_len[3] = H;
        send_frame(4, 1'b1, -1, -1, -1);
        exp_frames++;
        check_frame(1'b1);

        // Too many lines.
        go_idle();
        arm();
        set_lens(5, H);
        send_frame(5, 1'b1, -1, -1, -1);
        exp_frames++;
        check_frame(1'b1);

        // Stop pulsed mid-frame: frame completes, then idle.
        go_idle();
        arm();
        exp_after_done = 1'b0;
        set_lens(4, H);
        send_frame(4, 1'b1, -1, 1, -1);
        exp_frames++;
        check_frame(1'b0);
        exp_after_done = 1'b1;
        go_idle();
        send_frame(4, 1'b0, -1, -1, -1);
        chk("ignored_frame_cont", 64'(oFrame_Cont), 64'(exp_frames));
        chk("ignored_frame_busy", 64'(oBusy), 64'(0));
        iStart = 1'b1;
        iStop  = 1'b1;
        repeat (3) cyc();
        chk("start_and_stop_idle", 64'(oBusy), 64'(0));
        iStop = 1'b0;
        cyc();
        cyc();

        // Reset during line 2, then resume at the next full frame.
        send_frame(4, 1'b1, -1, -1, 2);
        chk("post_reset_frame_cont", 64'(oFrame_Cont), 64'(0));
        chk("post_reset_busy", 64'(oBusy), 64'(1));
        send_frame(4, 1'b1, -1, -1, -1);
        exp_frames++;
        check_frame(1'b0);

        // Randomized geometry.
        for (int it = 0; it < 4; it++) begin
            go_idle();
            arm();
            nl  = $urandom_range(V + 1, V - 1);
            err = (nl > V);
            for (int l = 0; l < nl; l++) begin
                line_len[l] = $urandom_range(H + 2, H - 2);
                if (line_len[l] != H) err = 1'b1;
            end
            send_frame(nl, 1'b1, -1, -1, -1);
            exp_frames++;
            check_frame(err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
